// File: rtl/int_prio_ctrl_if.sv
// Signal bundle between int_prio_ctrl, the interrupt sources and the CPU control unit.
// master = CPU/source side, slave = the controller.
interface int_prio_ctrl_if #(
    parameter int unsigned NUM_SRC = 5
);
    logic [NUM_SRC-1:0] src_req;
    logic               if_in;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               int_ack;
    logic               eoi;
    logic               irq;
    logic [2:0]         int_num;
    logic [7:0]         int_vec;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] mask_q;

    modport master (
        output src_req, if_in, mask_we, mask_wdata, int_ack, eoi,
        input  irq, int_num, int_vec, pending, in_service, mask_q
    );

    modport slave (
        input  src_req, if_in, mask_we, mask_wdata, int_ack, eoi,
        output irq, int_num, int_vec, pending, in_service, mask_q
    );
endinterface

// File: rtl/int_prio_ctrl.sv
// Prioritising interrupt controller: edge-latched pending bits, mask, fixed priority, in-service tracking.
// Define INT_NEST_EN to allow higher-priority sources to nest over an in-service one.
module int_prio_ctrl #(
    parameter int unsigned NUM_SRC    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h08,
    parameter logic [7:0]  VEC_STRIDE = 8'h04
) (
    input logic            clk,
    input logic            reset,
    int_prio_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t             state, state_n;
    logic [NUM_SRC-1:0] pending, pending_n;
    logic [NUM_SRC-1:0] in_service, in_service_n;
    logic [NUM_SRC-1:0] mask_q, mask_n;
    logic [NUM_SRC-1:0] src_q;
    logic               irq, irq_n;
    logic [2:0]         int_num, int_num_n;
    logic [7:0]         int_vec, int_vec_n;

    logic [NUM_SRC-1:0] eligible, cand, sel;
    logic               win_any, eoi_any;
    logic [2:0]         win_idx, eoi_idx;

`ifdef INT_NEST_EN
    logic seen;
    always_comb begin
        seen     = 1'b0;
        eligible = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            seen        = seen | in_service[i];
            eligible[i] = ~seen;
        end
    end
`else
    always_comb begin
        eligible = (|in_service) ? '0 : '1;
    end
`endif

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        cand    = pending & ~mask_q & eligible;
        win_any = 1'b0;
        win_idx = '0;
        eoi_any = 1'b0;
        eoi_idx = '0;
        sel     = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (cand[i-1]) begin
                win_any = 1'b1;
                win_idx = 3'(i - 1);
            end
            if (in_service[i-1]) begin
                eoi_any = 1'b1;
                eoi_idx = 3'(i - 1);
            end
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sel[i] = (int_num == 3'(i + 1));
        end
    end

    always_comb begin
        state_n      = state;
        irq_n        = irq;
        int_num_n    = int_num;
        int_vec_n    = int_vec;
        pending_n    = pending;
        in_service_n = in_service;
        mask_n       = bus.mask_we ? bus.mask_wdata : mask_q;

        // EOI works on the pre-ack in_service value; the ack set is OR-ed on afterwards.
        if (bus.eoi && eoi_any) begin
            in_service_n[eoi_idx] = 1'b0;
        end

        case (state)
            IDLE: begin
                if (bus.if_in && win_any) begin
                    state_n   = REQ;
                    irq_n     = 1'b1;
                    int_num_n = win_idx + 3'd1;
                    int_vec_n = VEC_BASE + {5'b0, win_idx} * VEC_STRIDE;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    pending_n    = pending & ~sel;
                    in_service_n = in_service_n | sel;
                    irq_n        = 1'b0;
                    state_n      = ACK;
                end else if (!bus.if_in || !(|(cand & sel))) begin
                    irq_n     = 1'b0;
                    int_num_n = '0;
                    int_vec_n = '0;
                    state_n   = IDLE;
                end
            end
            ACK: begin
                int_num_n = '0;
                int_vec_n = '0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase

        pending_n = pending_n | (bus.src_req & ~src_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            in_service <= '0;
            mask_q     <= '1;
            src_q      <= '0;
            irq        <= 1'b0;
            int_num    <= '0;
            int_vec    <= '0;
        end else begin
            pending    <= pending_n;
            in_service <= in_service_n;
            mask_q     <= mask_n;
            src_q      <= bus.src_req;
            irq        <= irq_n;
            int_num    <= int_num_n;
            int_vec    <= int_vec_n;
        end
    end

    assign bus.irq        = irq;
    assign bus.int_num    = int_num;
    assign bus.int_vec    = int_vec;
    assign bus.pending    = pending;
    assign bus.in_service = in_service;
    assign bus.mask_q     = mask_q;
endmodule

// File: tb/tb_int_prio_ctrl.sv
// Self-checking bench for int_prio_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_int_prio_ctrl;
    localparam int N = 5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int_prio_ctrl_if #(.NUM_SRC(N)) bus();

    int_prio_ctrl #(
        .NUM_SRC(N),
        .VEC_BASE(8'h08),
        .VEC_STRIDE(8'h04)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [26:0] outs;
    assign outs = {bus.irq, bus.int_num, bus.int_vec, bus.pending, bus.in_service, bus.mask_q};

    // Behavioural model: phase 0 = no request, 1 = irq raised awaiting ack, 2 = vector fetch cycle.
    bit [N-1:0] m_pend, m_isv, m_mask, m_prev;
    int         m_phase;
    int         m_num;

    function automatic bit m_cand(int k);
        bit blocked;
        blocked = 1'b0;
`ifdef INT_NEST_EN
        for (int j = 0; j <= k; j++) if (m_isv[j]) blocked = 1'b1;
`else
        blocked = (m_isv != 0);
`endif
        return m_pend[k] && !m_mask[k] && !blocked;
    endfunction

    function automatic logic [26:0] model_outs();
        logic [2:0] num;
        logic [7:0] vec;
        num = (m_phase == 0) ? 3'd0 : 3'(m_num);
        vec = (m_phase == 0) ? 8'h00 : 8'(8 + 4 * (m_num - 1));
        return {(m_phase == 1), num, vec, m_pend, m_isv, m_mask};
    endfunction

    task automatic model_edge();
        bit [N-1:0] np, ni;
        int win, low;
        if (reset) begin
            m_pend = '0; m_isv = '0; m_mask = '1; m_prev = '0; m_phase = 0; m_num = 0;
            return;
        end
        win = 0;
        low = -1;
        for (int k = N - 1; k >= 0; k--) if (m_cand(k)) win = k + 1;
        for (int k = N - 1; k >= 0; k--) if (m_isv[k]) low = k;
        np = m_pend;
        ni = m_isv;
        if (bus.eoi && low >= 0) ni[low] = 1'b0;
        case (m_phase)
            0: if (bus.if_in && win != 0) begin m_num = win; m_phase = 1; end
            1: begin
                if (bus.int_ack) begin
                    np[m_num-1] = 1'b0;
                    ni[m_num-1] = 1'b1;
                    m_phase = 2;
                end else if (!bus.if_in || !m_cand(m_num - 1)) begin
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
        np = np | (bus.src_req & ~m_prev);
        m_prev = bus.src_req;
        m_pend = np;
        m_isv  = ni;
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endtask

    task automatic cyc(input logic [N-1:0] s, input logic a, input logic e);
        bus.src_req = s;
        bus.int_ack = a;
        bus.eoi     = e;
        model_edge();
        @(posedge clk);
        #1;
        bus.mask_we = 1'b0;
        bus.int_ack = 1'b0;
        bus.eoi     = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        cyc(bus.src_req, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (outs !== {1'b0, 3'd0, 8'h00, 5'b00000, 5'b00000, 5'b11111}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", outs, {1'b0, 3'd0, 8'h00, 15'h001f});
        end
        checks++;
        if (outs !== model_outs()) begin
            errors++; $display("FAIL reset_model: got %h expected %h", outs, model_outs());
        end
    endtask

    task automatic test_basic();
        write_mask('0);
        checks++;
        if (bus.mask_q !== 5'b00000) begin errors++; $display("FAIL basic_mask: got %b expected 00000", bus.mask_q); end
        cyc(5'b00100, 1'b0, 1'b0);
        checks++;
        if ({bus.pending, bus.irq} !== {5'b00100, 1'b0}) begin
            errors++; $display("FAIL basic_pending: got %b/%b expected 00100/0", bus.pending, bus.irq);
        end
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.int_num, bus.int_vec} !== {1'b1, 3'd3, 8'h10}) begin
            errors++; $display("FAIL basic_irq: got %b/%0d/%h expected 1/3/10", bus.irq, bus.int_num, bus.int_vec);
        end
        cyc('0, 1'b1, 1'b0);
        checks++;
        if ({bus.pending, bus.in_service, bus.irq, bus.int_num} !== {5'b00000, 5'b00100, 1'b0, 3'd3}) begin
            errors++; $display("FAIL basic_ack: got %b/%b/%b/%0d expected 00000/00100/0/3",
                               bus.pending, bus.in_service, bus.irq, bus.int_num);
        end
        cyc('0, 1'b0, 1'b0);
        checks++;
        if (bus.int_num !== 3'd0) begin errors++; $display("FAIL basic_after_ack: got %0d expected 0", bus.int_num); end
        cyc('0, 1'b0, 1'b1);
        checks++;
        if (outs !== model_outs()) begin errors++; $display("FAIL basic_eoi: got %h expected %h", outs, model_outs()); end
    endtask

    task automatic test_priority();
        cyc(5'b01010, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        checks++;
        if (bus.int_num !== 3'd2) begin errors++; $display("FAIL prio_first: got %0d expected 2", bus.int_num); end
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.int_num, bus.int_vec} !== {1'b1, 3'd4, 8'h14}) begin
            errors++; $display("FAIL prio_second: got %b/%0d/%h expected 1/4/14", bus.irq, bus.int_num, bus.int_vec);
        end
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
        checks++;
        if (outs !== model_outs()) begin errors++; $display("FAIL prio_model: got %h expected %h", outs, model_outs()); end
    endtask

    task automatic test_mask();
        write_mask(5'b00001);
        cyc(5'b00001, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.pending, bus.irq} !== {5'b00001, 1'b0}) begin
            errors++; $display("FAIL mask_blocked: got %b/%b expected 00001/0", bus.pending, bus.irq);
        end
        write_mask('0);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_same_cycle: got %b expected 0", bus.irq); end
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.int_num, bus.int_vec} !== {1'b1, 3'd1, 8'h08}) begin
            errors++; $display("FAIL mask_release: got %b/%0d/%h expected 1/1/08", bus.irq, bus.int_num, bus.int_vec);
        end
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
    endtask

    task automatic test_nesting();
        cyc(5'b10000, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc(5'b00001, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
`ifdef INT_NEST_EN
        checks++;
        if ({bus.irq, bus.int_num} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL nest_irq: got %b/%0d expected 1/1", bus.irq, bus.int_num);
        end
        cyc('0, 1'b1, 1'b0);
        checks++;
        if (bus.in_service !== 5'b10001) begin errors++; $display("FAIL nest_isv: got %b expected 10001", bus.in_service); end
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
`else
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.in_service} !== {1'b0, 5'b10000}) begin
            errors++; $display("FAIL nonest_hold: got %b/%b expected 0/10000", bus.irq, bus.in_service);
        end
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.int_num} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL nonest_after_eoi: got %b/%0d expected 1/1", bus.irq, bus.int_num);
        end
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
`endif
        checks++;
        if (outs !== model_outs()) begin errors++; $display("FAIL nest_model: got %h expected %h", outs, model_outs()); end
    endtask

    task automatic test_if_drop();
        cyc(5'b00010, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        bus.if_in = 1'b0;
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.int_num, bus.pending} !== {1'b0, 3'd0, 5'b00010}) begin
            errors++; $display("FAIL ifdrop_drop: got %b/%0d/%b expected 0/0/00010", bus.irq, bus.int_num, bus.pending);
        end
        bus.if_in = 1'b1;
        cyc('0, 1'b0, 1'b0);
        checks++;
        if ({bus.irq, bus.int_num} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL ifdrop_reraise: got %b/%0d expected 1/2", bus.irq, bus.int_num);
        end
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_req();
        cyc(5'b10100, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc('0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (outs !== {1'b0, 3'd0, 8'h00, 5'b00000, 5'b00000, 5'b11111}) begin
            errors++; $display("FAIL reset_in_req: got %h expected %h", outs, {1'b0, 3'd0, 8'h00, 15'h001f});
        end
    endtask

    task automatic test_random();
        logic [N-1:0] s;
        logic         a;
        write_mask('0);
        for (int n = 0; n < 800; n++) begin
            s = bus.src_req;
            if ($urandom_range(2) == 0) s = N'($urandom);
            bus.if_in = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) begin
                bus.mask_we    = 1'b1;
                bus.mask_wdata = N'($urandom) & N'($urandom);
            end
            reset = ($urandom_range(299) == 0);
            a = bus.irq ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            cyc(s, a, $urandom_range(5) == 0);
            checks++;
            if (outs !== model_outs()) begin
                errors++; $display("FAIL random_%0d: got %h expected %h", n, outs, model_outs());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        bus.src_req    = '0;
        bus.if_in      = 1'b1;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.int_ack    = 1'b0;
        bus.eoi        = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_nesting();
        test_if_drop();
        test_reset_in_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_prio_ctrl.md
Name: int_prio_ctrl

Overview:
- Prioritising interrupt controller between the interrupt/exception sources and the CPU control unit.
- Latches request edges into pending bits, applies a software mask, and picks the highest-priority source.
- Drives a single irq line to the control unit and, on acknowledge, supplies int_num and a vector byte for the PC load.
- Tracks in-service sources until end-of-interrupt (RET).

Parameters:
NUM_SRC, 5, number of sources (1..7); source i reports int_num = i+1
VEC_BASE, 8'h08, vector address of int_num 1
VEC_STRIDE, 8'h04, vector spacing per int_num

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
src_req  in  NUM_SRC  raw request levels; bit 0 highest priority
if_in  in  1  CPU global interrupt enable flag
mask_we  in  1  write strobe for mask register
mask_wdata  in  NUM_SRC  new mask (1 = source blocked)
int_ack  in  1  one-cycle acknowledge from control unit (vector-fetch state)
eoi  in  1  one-cycle end-of-interrupt (RET executed)
irq  out  1  interrupt request to control unit
int_num  out  3  winning source number, 0 = none
int_vec  out  8  VEC_BASE + (int_num-1)*VEC_STRIDE, truncated to 8 bits; 0 when int_num = 0
pending  out  NUM_SRC  pending latch contents
in_service  out  NUM_SRC  in-service register contents
mask_q  out  NUM_SRC  current mask

Behaviour:
- Reset (synchronous, active-high, one clk): pending=0, in_service=0, mask_q=all 1s, irq=0, int_num=0, int_vec=0, state=IDLE, edge-detect history=0.
- Edge detect: pending[i] sets on a 0->1 transition of src_req[i], sampled at a clk edge. Levels held high do not re-set pending after it is cleared.
- Mask: mask_we loads mask_q at the clk edge. The new mask affects arbitration from the following cycle.
- Candidate set = pending & ~mask_q & eligible. Winner = lowest set index.
- eligible: bit i is eligible when no in_service bit j <= i is set. A source cannot preempt itself or a higher-priority service.
- State machine:
  - IDLE: when if_in=1 and a candidate exists, register the winner into int_num/int_vec, set irq=1, go to REQ. One-cycle latency from the pending set to irq.
  - REQ: int_num/int_vec are frozen. If int_ack=1: clear pending[int_num-1], set in_service[int_num-1], drop irq, go to ACK. If the winner leaves the candidate set (masked or if_in=0) before ack: drop irq, int_num=0, go to IDLE.
  - ACK: one cycle. int_num/int_vec are still held for the PC load. Then int_num=0 and go to IDLE.
- int_ack outside REQ: ignored.
- eoi: clears the lowest-index set in_service bit. With in_service=0, no effect.
- Simultaneous events in one cycle:
  - New edge on the acked source together with int_ack: the clear happens first, then the set. Pending stays 1.
  - eoi with int_ack: eoi acts on the in_service value before this cycle's set.
  - Higher-priority edge during REQ: no switch. The frozen winner is served first; the new source is arbitrated from IDLE afterwards.

Optional Feature:
- Macro: INT_NEST_EN.
- Defined: nesting per the eligible rule above. A higher-priority source may interrupt an in-service one, and in_service may hold several bits.
- Undefined: eligible = all 0 whenever any in_service bit is set. No new irq until eoi, and in_service holds at most one bit.

Test Plan:
- Reset, mask_wdata=5'b00000 written, pulse src_req[2] -> pending=00100, irq=1 next cycle, int_num=3, int_vec=8'h10; int_ack -> pending=0, in_service=00100; int_num=0 after ACK.
- src_req[3] and src_req[1] rise together -> int_num=2 first. After ack and eoi, int_num=4 is served.
- Mask bit 0 set, pulse src_req[0] -> pending=00001, irq=0. Clear the mask -> irq=1 next cycle, int_num=1, int_vec=8'h08.
- Source 4 in service, pulse src_req[0] -> with INT_NEST_EN: irq, int_num=1, then in_service=10001; without it: irq stays 0 until eoi.
- irq up for int_num=2, drop if_in before ack -> irq=0, int_num=0, pending bit remains. Re-raise if_in -> irq again.
- Assert reset while in REQ with pending/in_service nonzero -> all outputs zero and mask_q=all 1s on the next clk edge.
